// File: rtl/sb_cfg_pkg.sv
// sb_cfg_pkg: shared types and sizing helpers for the edge-column switch block.
//   clog2     : ceiling log2 of a positive integer (clog2(1) = 0)
//   sel_w     : select width of one (num_pin+1)-input track mux
//   cfg_bits  : length of the configuration chain for a given geometry
//   state_t   : configuration FSM state (UNCONF / SHIFT / ACTIVE)
package sb_cfg_pkg;

  typedef enum logic [1:0] {
    UNCONF = 2'd0,
    SHIFT  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int sel_w(input int num_pin);
    return clog2(num_pin + 1);
  endfunction

  function automatic int cfg_bits(input int chan_width, input int num_pin);
    return 2 * chan_width * sel_w(num_pin);
  endfunction

endpackage

// File: rtl/sb_cfg_chain.sv
// sb_cfg_chain: configuration shadow chain with commit checking.
//   clk, rst        : clock, synchronous active-high reset
//   config_enable   : high shifts the chain; first low cycle after a shift
//                     burst is the commit attempt
//   ccff_head       : serial data in;  ccff_tail : serial data out (shadow MSB)
//   active          : committed configuration vector driving the muxes
//   cfg_valid       : active holds a committed configuration
//   cfg_error       : last commit attempt had the wrong bit count (sticky)
//   state_dbg       : current FSM state
//
// Handshake: there is no ready; every cycle config_enable is high one bit is
// accepted from ccff_head. A burst ends on the first cycle config_enable is
// sampled low, and only a burst of exactly CFG_BITS shifts reaches active.
module sb_cfg_chain
  import sb_cfg_pkg::*;
#(
  parameter int CFG_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                config_enable,
  input  logic                ccff_head,
  output logic                ccff_tail,
  output logic [CFG_BITS-1:0] active,
  output logic                cfg_valid,
  output logic                cfg_error,
  output state_t              state_dbg
);

  // Counter saturates at CFG_BITS+1 so an overrun can never wrap back
  // onto CFG_BITS and look like a good load.
  localparam int CNT_W = clog2(CFG_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

  state_t              state_q, state_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                error_q, error_d;
  logic                commit_ok, commit_bad;

  // State register and all configuration flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= UNCONF;
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  // Next-state logic. A failed commit falls back to ACTIVE only when an
  // older good configuration is still in place.
  always_comb begin
    state_d = state_q;
    if (config_enable) begin
      state_d = SHIFT;
    end else if (state_q == SHIFT) begin
      state_d = ((cnt_q == CNT_FULL) || valid_q) ? ACTIVE : UNCONF;
    end
  end

  // FSM outputs: commit strobes on the cycle a shift burst ends.
  always_comb begin
    commit_ok  = 1'b0;
    commit_bad = 1'b0;
    if ((state_q == SHIFT) && !config_enable) begin
      if (cnt_q == CNT_FULL) commit_ok  = 1'b1;
      else                   commit_bad = 1'b1;
    end
  end

  // Datapath next values.
  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    valid_d  = valid_q;
    error_d  = error_q;
    if (config_enable) begin
      shadow_d = {shadow_q[CFG_BITS-2:0], ccff_head};
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
    end else if (state_q == SHIFT) begin
      cnt_d = '0;
    end
    if (commit_ok) begin
      active_d = shadow_q;
      valid_d  = 1'b1;
      error_d  = 1'b0;
    end
    if (commit_bad) begin
      error_d = 1'b1;
    end
  end

  assign ccff_tail = shadow_q[CFG_BITS-1];
  assign active    = active_q;
  assign cfg_valid = valid_q;
  assign cfg_error = error_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/sb_param_shadow_cfg.sv
// sb_param_shadow_cfg: edge-column switch block with shadowed configuration.
//   prog_clk, pReset              : clock, synchronous active-high reset
//   config_enable, ccff_head/tail : configuration chain
//   chanx_right_in/chany_bottom_in: incoming tracks (crossing source, sel 0)
//   right_pin_in/bottom_pin_in    : grid pins (sel 1..NUM_PIN)
//   chanx_right_out/chany_bottom_out : driven tracks (0 while unconfigured)
//   cfg_valid, cfg_error          : configuration status
//   cfg_state_dbg                 : configuration FSM state
// Mux j takes active[j*SEL_W +: SEL_W]; j < CHAN_WIDTH drives the right
// tracks, the rest drive the bottom tracks. Selects above NUM_PIN give 0.
module sb_param_shadow_cfg
  import sb_cfg_pkg::*;
#(
  parameter int CHAN_WIDTH = 12,
  parameter int NUM_PIN    = 6
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  config_enable,
  input  logic                  ccff_head,
  output logic                  ccff_tail,
  input  logic [CHAN_WIDTH-1:0] chanx_right_in,
  input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
  input  logic [NUM_PIN-1:0]    right_pin_in,
  input  logic [NUM_PIN-1:0]    bottom_pin_in,
  output logic [CHAN_WIDTH-1:0] chanx_right_out,
  output logic [CHAN_WIDTH-1:0] chany_bottom_out,
  output logic                  cfg_valid,
  output logic                  cfg_error,
  output state_t                cfg_state_dbg
);

  localparam int SEL_W    = sel_w(NUM_PIN);
  localparam int CFG_BITS = cfg_bits(CHAN_WIDTH, NUM_PIN);
  // Candidate vectors are padded to a full power of two so any select
  // value indexes a defined bit; the padding bits are tied to 0.
  localparam int MUX_N    = 1 << SEL_W;

  logic [CFG_BITS-1:0] active;

  sb_cfg_chain #(
    .CFG_BITS (CFG_BITS)
  ) u_chain (
    .clk           (prog_clk),
    .rst           (pReset),
    .config_enable (config_enable),
    .ccff_head     (ccff_head),
    .ccff_tail     (ccff_tail),
    .active        (active),
    .cfg_valid     (cfg_valid),
    .cfg_error     (cfg_error),
    .state_dbg     (cfg_state_dbg)
  );

  for (genvar i = 0; i < CHAN_WIDTH; i++) begin : g_mux
    logic [SEL_W-1:0] sel_r, sel_b;
    logic [MUX_N-1:0] cand_r, cand_b;

    assign sel_r = active[i*SEL_W +: SEL_W];
    assign sel_b = active[(CHAN_WIDTH+i)*SEL_W +: SEL_W];

    // Crossing track is mirrored: mux i listens to track CHAN_WIDTH-1-i.
    always_comb begin
      cand_r             = '0;
      cand_r[0]          = chany_bottom_in[CHAN_WIDTH-1-i];
      cand_r[NUM_PIN:1]  = right_pin_in;
      cand_b             = '0;
      cand_b[0]          = chanx_right_in[CHAN_WIDTH-1-i];
      cand_b[NUM_PIN:1]  = bottom_pin_in;
    end

    assign chanx_right_out[i]  = cfg_valid & cand_r[sel_r];
    assign chany_bottom_out[i] = cfg_valid & cand_b[sel_b];
  end

endmodule

// File: tb/tb_sb_param_shadow_cfg.sv
module tb_sb_param_shadow_cfg;
  import sb_cfg_pkg::*;

  localparam int CW = 4;
  localparam int NP = 2;
  localparam int SW = 2;
  localparam int CB = 16;

  // ---------------- clock / reset / DUT ----------------
  logic          prog_clk = 1'b0;
  logic          pReset = 1'b1;
  logic          config_enable = 1'b0;
  logic          ccff_head = 1'b0;
  logic          ccff_tail;
  logic [CW-1:0] chanx_right_in = '0;
  logic [CW-1:0] chany_bottom_in = '0;
  logic [NP-1:0] right_pin_in = '0;
  logic [NP-1:0] bottom_pin_in = '0;
  logic [CW-1:0] chanx_right_out;
  logic [CW-1:0] chany_bottom_out;
  logic          cfg_valid;
  logic          cfg_error;
  state_t        cfg_state_dbg;

  always #5 prog_clk = ~prog_clk;

  sb_param_shadow_cfg #(.CHAN_WIDTH(CW), .NUM_PIN(NP)) dut (
    .prog_clk         (prog_clk),
    .pReset           (pReset),
    .config_enable    (config_enable),
    .ccff_head        (ccff_head),
    .ccff_tail        (ccff_tail),
    .chanx_right_in   (chanx_right_in),
    .chany_bottom_in  (chany_bottom_in),
    .right_pin_in     (right_pin_in),
    .bottom_pin_in    (bottom_pin_in),
    .chanx_right_out  (chanx_right_out),
    .chany_bottom_out (chany_bottom_out),
    .cfg_valid        (cfg_valid),
    .cfg_error        (cfg_error),
    .cfg_state_dbg    (cfg_state_dbg)
  );

  int total = 0;
  int bad   = 0;
  bit hold_data = 1'b0;

  // ---------------- behavioural model ----------------
  // m_shadow[k] = bit shifted in k shifts ago (k = 0 newest).
  bit          m_shadow[$];
  bit [CB-1:0] m_active;
  bit          m_valid, m_err, m_in_shift;
  int          m_nshift;

  task automatic model_reset();
    m_shadow = {};
    for (int k = 0; k < CB; k++) m_shadow.push_back(1'b0);
    m_active   = '0;
    m_valid    = 1'b0;
    m_err      = 1'b0;
    m_in_shift = 1'b0;
    m_nshift   = 0;
  endtask

  task automatic model_edge(bit rst, bit en, bit head);
    if (rst) begin
      model_reset();
    end else if (en) begin
      m_shadow.push_front(head);
      void'(m_shadow.pop_back());
      m_nshift++;
      m_in_shift = 1'b1;
    end else if (m_in_shift) begin
      if (m_nshift == CB) begin
        for (int k = 0; k < CB; k++) m_active[k] = m_shadow[k];
        m_valid = 1'b1;
        m_err   = 1'b0;
      end else begin
        m_err = 1'b1;
      end
      m_nshift   = 0;
      m_in_shift = 1'b0;
    end
  endtask

  function automatic int sel_of(int j);
    return 2 * int'(m_active[j*SW+1]) + int'(m_active[j*SW]);
  endfunction

  function automatic bit pick(int sel, bit crossing, bit [NP-1:0] pins);
    if (sel == 0) return crossing;
    if (sel <= NP) return pins[sel-1];
    return 1'b0;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [CW-1:0] exp_r, exp_b;
    state_t exp_s;
    for (int i = 0; i < CW; i++) begin
      exp_r[i] = m_valid & pick(sel_of(i), chany_bottom_in[CW-1-i], right_pin_in);
      exp_b[i] = m_valid & pick(sel_of(CW+i), chanx_right_in[CW-1-i], bottom_pin_in);
    end
    exp_s = m_in_shift ? SHIFT : (m_valid ? ACTIVE : UNCONF);
    chk("ccff_tail", 32'(ccff_tail), 32'(m_shadow[CB-1]));
    chk("cfg_valid", 32'(cfg_valid), 32'(m_valid));
    chk("cfg_error", 32'(cfg_error), 32'(m_err));
    chk("state", 32'(cfg_state_dbg), 32'(exp_s));
    chk("chanx_right_out", 32'(chanx_right_out), 32'(exp_r));
    chk("chany_bottom_out", 32'(chany_bottom_out), 32'(exp_b));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(bit en, bit head, bit rst);
    config_enable = en;
    ccff_head     = head;
    pReset        = rst;
    if (!hold_data) begin
      chanx_right_in  = CW'($urandom);
      chany_bottom_in = CW'($urandom);
      right_pin_in    = NP'($urandom);
      bottom_pin_in   = NP'($urandom);
    end
    @(posedge prog_clk);
    model_edge(rst, en, head);
    #1;
    compare_all();
  endtask

  // Shift n bits (config MSB first when n fits) and end with a commit cycle.
  task automatic load(bit [CB-1:0] cfg, int n);
    for (int k = 0; k < n; k++) begin
      step(1'b1, (k < CB) ? cfg[CB-1-k] : 1'($urandom_range(0, 1)), 1'b0);
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ones_cnt, first_one, n;
    bit [CB-1:0] cfg;
    model_reset();

    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("rst_valid", 32'(cfg_valid), 32'd0);
    chk("rst_error", 32'(cfg_error), 32'd0);
    chk("rst_tail", 32'(ccff_tail), 32'd0);
    chk("rst_outs", {24'd0, chanx_right_out, chany_bottom_out}, 32'd0);

    // All selects 0: right mux 3 listens to chany_bottom_in[0].
    load(16'h0000, CB);
    chk("commit_valid", 32'(cfg_valid), 32'd1);
    hold_data = 1'b1;
    chany_bottom_in = 4'b0001;
    step(1'b0, 1'b0, 1'b0);
    chk("sel0_cross", 32'(chanx_right_out), 32'h8);
    hold_data = 1'b0;

    // Underrun from unconfigured.
    step(1'b0, 1'b0, 1'b1);
    load(CB'($urandom), CB - 1);
    chk("under_err", 32'(cfg_error), 32'd1);
    chk("under_valid", 32'(cfg_valid), 32'd0);
    chk("under_outs", {24'd0, chanx_right_out, chany_bottom_out}, 32'd0);

    // mux 0 sel=2 (right_pin_in[1]), mux 4 sel=3 (tied 0).
    load(16'h0302, CB);
    hold_data = 1'b1;
    right_pin_in = 2'b10;
    for (int r = 0; r < 4; r++) begin
      chanx_right_in = CW'($urandom);
      bottom_pin_in  = NP'($urandom);
      step(1'b0, 1'b0, 1'b0);
      chk("pin_sel2", 32'(chanx_right_out[0]), 32'd1);
      chk("sel3_zero", 32'(chany_bottom_out[0]), 32'd0);
    end
    // Overrun keeps the old routing; commit right back-to-back.
    load(CB'($urandom), CB + 1);
    chk("over_err", 32'(cfg_error), 32'd1);
    chk("over_keep", 32'(chanx_right_out[0]), 32'd1);
    hold_data = 1'b0;

    // Chain pass-through from a cleared shadow.
    step(1'b0, 1'b0, 1'b1);
    ones_cnt = 0;
    first_one = 0;
    for (int k = 0; k < 2 * CB; k++) begin
      step(1'b1, k < CB, 1'b0);
      if (ccff_tail) begin
        ones_cnt++;
        if (first_one == 0) first_one = k + 1;
      end
    end
    chk("pass_ones", 32'(ones_cnt), 32'd16);
    chk("pass_first", 32'(first_one), 32'd16);
    step(1'b0, 1'b0, 1'b0);

    // Reset in the middle of a reconfiguration.
    load(16'hA5C3, CB);
    for (int k = 0; k < 8; k++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("midrst_valid", 32'(cfg_valid), 32'd0);
    chk("midrst_tail", 32'(ccff_tail), 32'd0);
    chk("midrst_outs", {24'd0, chanx_right_out, chany_bottom_out}, 32'd0);
    load(16'h1E2D, CB);
    chk("midrst_reload", 32'(cfg_valid), 32'd1);

    // Randomised bursts, gaps and occasional resets.
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 4))
        0: n = CB - 1;
        1: n = CB + 1;
        2: n = $urandom_range(1, 40);
        default: n = CB;
      endcase
      cfg = CB'($urandom);
      load(cfg, n);
      for (int g = $urandom_range(0, 3); g > 0; g--) step(1'b0, 1'b0, 1'b0);
      if ($urandom_range(0, 19) == 0) step(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
